// File: rtl/voting_machine_multi_pkg.sv
// Shared constants for the multi-candidate voting machine.
// Holds FSM state encodings, tie policies and the code-width helper.
package voting_machine_multi_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_OPEN  = 2'd1;
    localparam state_t ST_TALLY = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int TIE_LOWEST = 0;
    localparam int TIE_NONE   = 1;

    // Code 0 is reserved for abstain, so n candidates need n+1 codes.
    function automatic int cand_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/voting_machine_multi_if.sv
// Vote port of the voting machine: valid/ready handshake plus the
// candidate code.
interface voting_machine_multi_if #(
    parameter int CAND_W = 3
) ();

    logic              vote_valid;
    logic [CAND_W-1:0] candidate;
    logic              vote_ready;

    modport master (
        output vote_valid,
        output candidate,
        input  vote_ready
    );

    modport slave (
        input  vote_valid,
        input  candidate,
        output vote_ready
    );

endinterface

// File: rtl/voting_machine_multi_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/voting_machine_multi.sv
// Multi-candidate voting machine: poll lifecycle, saturating tallies
// and a one-candidate-per-cycle winner scan.
module voting_machine_multi
    import voting_machine_multi_pkg::*;
#(
    parameter  int NUM_CAND = 4,
    parameter  int CNT_W    = 8,
    parameter  int TIE_MODE = TIE_LOWEST,
    localparam int CAND_W   = cand_width(NUM_CAND),
    localparam int TOT_W    = CNT_W + CAND_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                open_poll_i,
    input  logic                close_poll_i,
    voting_machine_multi_if.slave vote,
    input  logic [CAND_W-1:0]   rd_idx_i,
    output logic [CNT_W-1:0]    rd_count_o,
    output logic [TOT_W-1:0]    total_votes_o,
    output logic [CNT_W-1:0]    rejected_o,
    output logic                busy_o,
    output logic [CAND_W-1:0]   winner_o,
    output logic                winner_valid_o,
    output logic                tie_o
);

    state_t              state_q, state_d;
    logic [CAND_W-1:0]   idx_q, idx_d;
    logic [CAND_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]    best_q, best_d;
    logic                tie_q, tie_d;

    logic [CNT_W-1:0]    cnt [NUM_CAND];
    logic [CNT_W-1:0]    scan_cnt;
    logic                ready;
    logic                accept;
    logic                code_ok;
    logic                enter_open;
    logic                enter_tally;
    logic                last_scan;

    assign ready       = (state_q == ST_OPEN);
    assign accept      = vote.vote_valid && ready;
    assign code_ok     = (vote.candidate != '0) &&
                         (vote.candidate <= CAND_W'(NUM_CAND));
    assign last_scan   = (idx_q == CAND_W'(NUM_CAND));
    assign enter_tally = (state_q == ST_OPEN) && close_poll_i;

    assign vote.vote_ready = ready;

    always_comb begin
        state_d    = state_q;
        enter_open = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (open_poll_i) begin
                    state_d    = ST_OPEN;
                    enter_open = 1'b1;
                end
            end
            ST_OPEN: begin
                if (close_poll_i) state_d = ST_TALLY;
            end
            ST_TALLY: begin
                if (last_scan) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_cnt   = '0;
        rd_count_o = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (idx_q == CAND_W'(i + 1)) scan_cnt = cnt[i];
            if (rd_idx_i == CAND_W'(i + 1)) rd_count_o = cnt[i];
        end
    end

    always_comb begin
        idx_d  = idx_q;
        win_d  = win_q;
        best_d = best_q;
        tie_d  = tie_q;
        if (enter_open || enter_tally) begin
            idx_d  = enter_tally ? CAND_W'(1) : '0;
            win_d  = '0;
            best_d = '0;
            tie_d  = 1'b0;
        end else if (state_q == ST_TALLY) begin
            idx_d = idx_q + 1'b1;
            if (scan_cnt > best_q) begin
                win_d  = idx_q;
                best_d = scan_cnt;
                tie_d  = 1'b0;
            end else if ((scan_cnt == best_q) && (best_q != '0)) begin
                tie_d = 1'b1;
            end
            // Tie policy is applied on the final scan step so DONE is clean.
            if (last_scan && (TIE_MODE == TIE_NONE) && tie_d) begin
                win_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            win_q   <= '0;
            best_q  <= '0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            best_q  <= best_d;
            tie_q   <= tie_d;
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (enter_open),
            .inc_i (accept && code_ok &&
                    (vote.candidate == CAND_W'(g + 1))),
            .cnt_o (cnt[g])
        );
    end

    sat_counter #(.W(TOT_W)) u_total (
        .clk   (clk),
        .rst   (rst),
        .clr_i (enter_open),
        .inc_i (accept && code_ok),
        .cnt_o (total_votes_o)
    );

    sat_counter #(.W(CNT_W)) u_rejected (
        .clk   (clk),
        .rst   (rst),
        .clr_i (enter_open),
        .inc_i (accept && !code_ok),
        .cnt_o (rejected_o)
    );

    assign busy_o         = (state_q == ST_TALLY);
    assign winner_valid_o = (state_q == ST_DONE);
    assign winner_o       = win_q;
    assign tie_o          = tie_q;

endmodule

// File: tb/tb_voting_machine_multi.sv
// Scoreboard bench: three DUT configurations driven by one stimulus
// stream; a monitor per DUT checks results when winner_valid rises.
module tb_voting_machine_multi;

    typedef struct {
        int w;
        int t;
        int tot;
        int rej;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic open_p = 1'b0;
    logic close_p = 1'b0;
    logic vv = 1'b0;
    logic [2:0] cand = '0;
    logic [2:0] rd_idx = '0;

    int n_chk = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [7:0]  rc0, rc1, rej0, rej1;
    logic [3:0]  rc2, rej2;
    logic [10:0] tot0, tot1;
    logic [6:0]  tot2;
    logic [2:0]  win0, win1, win2;
    logic busy0, busy1, busy2;
    logic wv0, wv1, wv2;
    logic tie0, tie1, tie2;

    always #5 clk = ~clk;

    voting_machine_multi_if #(.CAND_W(3)) vif0 ();
    voting_machine_multi_if #(.CAND_W(3)) vif1 ();
    voting_machine_multi_if #(.CAND_W(3)) vif2 ();

    assign vif0.vote_valid = vv;
    assign vif0.candidate  = cand;
    assign vif1.vote_valid = vv;
    assign vif1.candidate  = cand;
    assign vif2.vote_valid = vv;
    assign vif2.candidate  = cand;

    voting_machine_multi #(.NUM_CAND(4), .CNT_W(8), .TIE_MODE(0)) d0 (
        .clk(clk), .rst(rst), .open_poll_i(open_p), .close_poll_i(close_p),
        .vote(vif0), .rd_idx_i(rd_idx), .rd_count_o(rc0),
        .total_votes_o(tot0), .rejected_o(rej0), .busy_o(busy0),
        .winner_o(win0), .winner_valid_o(wv0), .tie_o(tie0)
    );

    voting_machine_multi #(.NUM_CAND(4), .CNT_W(8), .TIE_MODE(1)) d1 (
        .clk(clk), .rst(rst), .open_poll_i(open_p), .close_poll_i(close_p),
        .vote(vif1), .rd_idx_i(rd_idx), .rd_count_o(rc1),
        .total_votes_o(tot1), .rejected_o(rej1), .busy_o(busy1),
        .winner_o(win1), .winner_valid_o(wv1), .tie_o(tie1)
    );

    voting_machine_multi #(.NUM_CAND(4), .CNT_W(4), .TIE_MODE(0)) d2 (
        .clk(clk), .rst(rst), .open_poll_i(open_p), .close_poll_i(close_p),
        .vote(vif2), .rd_idx_i(rd_idx), .rd_count_o(rc2),
        .total_votes_o(tot2), .rejected_o(rej2), .busy_o(busy2),
        .winner_o(win2), .winner_valid_o(wv2), .tie_o(tie2)
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endfunction

    function automatic void cmp(input string tag, input exp_t e,
                                input int w, input int t,
                                input int tot, input int rej);
        chk({tag, ".winner"}, w, e.w);
        chk({tag, ".tie"}, t, e.t);
        chk({tag, ".total"}, tot, e.tot);
        chk({tag, ".rejected"}, rej, e.rej);
    endfunction

    function automatic void no_exp(input string tag);
        n_chk++;
        n_err++;
        $display("FAIL %s: winner_valid rose, no result expected", tag);
    endfunction

    initial begin
        logic p = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (wv0 && !p) begin
                if (q0.size() == 0) no_exp("d0");
                else begin
                    e = q0.pop_front();
                    cmp("d0", e, win0, tie0, tot0, rej0);
                end
            end
            p = wv0;
        end
    end

    initial begin
        logic p = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (wv1 && !p) begin
                if (q1.size() == 0) no_exp("d1");
                else begin
                    e = q1.pop_front();
                    cmp("d1", e, win1, tie1, tot1, rej1);
                end
            end
            p = wv1;
        end
    end

    initial begin
        logic p = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (wv2 && !p) begin
                if (q2.size() == 0) no_exp("d2");
                else begin
                    e = q2.pop_front();
                    cmp("d2", e, win2, tie2, tot2, rej2);
                end
            end
            p = wv2;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(input logic [2:0] c);
        vv = 1'b1;
        cand = c;
        cyc();
        vv = 1'b0;
    endtask

    task automatic open_poll();
        open_p = 1'b1;
        cyc();
        open_p = 1'b0;
    endtask

    task automatic close_poll();
        close_p = 1'b1;
        cyc();
        close_p = 1'b0;
    endtask

    task automatic push_all(input exp_t a, input exp_t b, input exp_t c);
        q0.push_back(a);
        q1.push_back(b);
        q2.push_back(c);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(wv0 && wv1 && wv2) && n < 20) begin
            cyc();
            n++;
        end
        chk("done_timeout", 32'(wv0 && wv1 && wv2), 1);
    endtask

    task automatic idle_chk(input string tag);
        rd_idx = 3'd3;
        #1;
        chk({tag, ".busy0"}, busy0, 0);
        chk({tag, ".wv0"}, wv0, 0);
        chk({tag, ".win0"}, win0, 0);
        chk({tag, ".tie0"}, tie0, 0);
        chk({tag, ".tot0"}, tot0, 0);
        chk({tag, ".rej0"}, rej0, 0);
        chk({tag, ".rdy0"}, vif0.vote_ready, 0);
        chk({tag, ".rc0"}, rc0, 0);
        chk({tag, ".busy1"}, busy1, 0);
        chk({tag, ".rdy1"}, vif1.vote_ready, 0);
        chk({tag, ".rc1"}, rc1, 0);
        chk({tag, ".busy2"}, busy2, 0);
        chk({tag, ".rdy2"}, vif2.vote_ready, 0);
        chk({tag, ".tot2"}, tot2, 0);
        chk({tag, ".rej2"}, rej2, 0);
        chk({tag, ".rc2"}, rc2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        idle_chk("reset");

        // Scenario 1: clear winner, exact busy / winner_valid timing
        open_poll();
        chk("s1.ready", vif0.vote_ready, 1);
        vote(3'd1); vote(3'd2); vote(3'd1);
        vote(3'd3); vote(3'd2); vote(3'd2);
        push_all('{2, 0, 6, 0}, '{2, 0, 6, 0}, '{2, 0, 6, 0});
        close_poll();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("s1.busy_t+%0d", k), busy0, 1);
            chk($sformatf("s1.wv_t+%0d", k), wv0, 0);
            if (k < 4) cyc();
        end
        cyc();
        chk("s1.wv_t+5", wv0, 1);
        chk("s1.busy_t+5", busy0, 0);
        rd_idx = 3'd2; #1;
        chk("s1.rd2", rc0, 3);
        rd_idx = 3'd1; #1;
        chk("s1.rd1", rc0, 2);
        rd_idx = 3'd0; #1;
        chk("s1.rd0", rc0, 0);
        rd_idx = 3'd5; #1;
        chk("s1.rd5", rc0, 0);
        rd_idx = 3'd7; #1;
        chk("s1.rd7", rc0, 0);
        vv = 1'b1; cand = 3'd3;
        chk("s1.done_ready", vif0.vote_ready, 0);
        cyc();
        vv = 1'b0;
        rd_idx = 3'd3; #1;
        chk("s1.done_rd3", rc0, 1);
        chk("s1.done_tot", tot0, 6);

        // Scenario 2: tie under both policies; vote during TALLY ignored
        open_poll();
        rd_idx = 3'd2; #1;
        chk("s2.clr_rd2", rc0, 0);
        chk("s2.clr_tot", tot0, 0);
        chk("s2.clr_wv", wv0, 0);
        vote(3'd1); vote(3'd3); vote(3'd3); vote(3'd1);
        push_all('{1, 1, 4, 0}, '{0, 1, 4, 0}, '{1, 1, 4, 0});
        close_poll();
        vv = 1'b1; cand = 3'd1;
        chk("s2.tally_ready", vif0.vote_ready, 0);
        chk("s2.tally_busy", busy0, 1);
        cyc();
        vv = 1'b0;
        wait_done();
        rd_idx = 3'd1; #1;
        chk("s2.rd1", rc0, 2);
        chk("s2.tot", tot0, 4);

        // Scenario 3: only invalid codes
        open_poll();
        vote(3'd0); vote(3'd5); vote(3'd7);
        push_all('{0, 0, 0, 3}, '{0, 0, 0, 3}, '{0, 0, 0, 3});
        close_poll();
        wait_done();

        // Scenario 4: saturation on the narrow DUT, vote with close
        open_poll();
        for (int i = 0; i < 19; i++) vote(3'd4);
        push_all('{4, 0, 20, 0}, '{4, 0, 20, 0}, '{4, 0, 20, 0});
        vv = 1'b1; cand = 3'd4; close_p = 1'b1;
        cyc();
        vv = 1'b0; close_p = 1'b0;
        wait_done();
        rd_idx = 3'd4; #1;
        chk("s4.rd4_w8", rc0, 20);
        chk("s4.rd4_w8_t1", rc1, 20);
        chk("s4.rd4_w4", rc2, 15);

        // Scenario 5: vote in IDLE ignored; open+close together in IDLE
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        vv = 1'b1; cand = 3'd2;
        chk("s5.idle_ready", vif0.vote_ready, 0);
        cyc();
        vv = 1'b0;
        chk("s5.idle_tot", tot0, 0);
        open_p = 1'b1; close_p = 1'b1;
        cyc();
        open_p = 1'b0; close_p = 1'b0;
        chk("s5.both_ready", vif0.vote_ready, 1);
        chk("s5.both_busy", busy0, 0);
        vote(3'd2);
        push_all('{2, 0, 1, 0}, '{2, 0, 1, 0}, '{2, 0, 1, 0});
        close_poll();
        wait_done();

        // Scenario 6: reset two cycles into TALLY
        open_poll();
        vote(3'd3); vote(3'd3);
        close_poll();
        cyc();
        cyc();
        chk("s6.busy_pre", busy0, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle_chk("s6.rst");
        open_poll();
        vote(3'd1);
        rd_idx = 3'd3; #1;
        chk("s6.rd3", rc0, 0);
        rd_idx = 3'd1; #1;
        chk("s6.rd1", rc0, 1);
        push_all('{1, 0, 1, 0}, '{1, 0, 1, 0}, '{1, 0, 1, 0});
        close_poll();
        wait_done();

        cyc();
        cyc();
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
